// File: rtl/imm_pkg.sv
// ----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the pipelined immediate generator.
//   - FMT_R..FMT_J : bit positions of the one-hot instruction format vector
//   - state_e      : occupancy state of the two-entry skid pipeline
//   - sext_to      : widen a 32-bit immediate to the configured XLEN
// Optional build macro used by the files importing this package:
//   IMM_FORMAT_CHECK_EN - adds the registered o_fmt_err flag on imm_gen_pipe
// ----------------------------------------------------------------------------
package imm_pkg;

    // Bit index of each format inside i_format. Lower index has priority.
    localparam int unsigned FMT_R = 0;
    localparam int unsigned FMT_I = 1;
    localparam int unsigned FMT_S = 2;
    localparam int unsigned FMT_B = 3;
    localparam int unsigned FMT_U = 4;
    localparam int unsigned FMT_J = 5;
    localparam int unsigned FMT_W = 6;

    // EMPTY: no beat held. ONE: output register valid. FULL: output and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Widen a 32-bit immediate to 64 bits. With xlen == 64 the upper word is a
    // copy of bit 31; with xlen == 32 it is zero and the caller keeps [31:0].
    function automatic logic [63:0] sext_to(input logic [31:0] imm, input int unsigned xlen);
        logic [63:0] wide;
        if (xlen == 64) begin
            wide = {{32{imm[31]}}, imm};
        end else begin
            wide = {32'h0, imm};
        end
        return wide;
    endfunction

endpackage : imm_pkg

// File: rtl/imm_extract.sv
// ----------------------------------------------------------------------------
// imm_extract
// Combinational immediate decoder for RV32/RV64 base instruction formats.
// The lowest set bit of i_format selects the format (R>I>S>B>U>J). R-type and
// an all-zero format both produce zero.
// Ports:
//   i_inst      in  32    instruction word
//   i_format    in  6     one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J
//   o_immediate out XLEN  sign-extended immediate
// ----------------------------------------------------------------------------
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]       i_inst,
    input  logic [FMT_W-1:0]  i_format,
    output logic [XLEN-1:0]   o_immediate
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm32;
    logic [63:0] w_imm64;
    logic        w_sign;

    assign w_sign  = i_inst[31];

    assign w_imm_i = {{20{w_sign}}, i_inst[31:20]};
    assign w_imm_s = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{w_sign}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_j = {{11{w_sign}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21],
                      1'b0};

    // Priority chain rather than a parallel case so that multi-hot formats
    // still resolve deterministically to the lowest set bit.
    always_comb begin
        w_imm32 = 32'h0;
        if (i_format[FMT_R]) begin
            w_imm32 = 32'h0;
        end else if (i_format[FMT_I]) begin
            w_imm32 = w_imm_i;
        end else if (i_format[FMT_S]) begin
            w_imm32 = w_imm_s;
        end else if (i_format[FMT_B]) begin
            w_imm32 = w_imm_b;
        end else if (i_format[FMT_U]) begin
            w_imm32 = w_imm_u;
        end else if (i_format[FMT_J]) begin
            w_imm32 = w_imm_j;
        end
    end

    assign w_imm64     = sext_to(w_imm32, XLEN);
    assign o_immediate = w_imm64[XLEN-1:0];

    // Opcode bits never feed an immediate; upper word is dropped when XLEN=32.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_inst[6:0], w_imm64};

endmodule : imm_extract

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator with a two-entry valid/ready skid pipeline.
// The immediate is decoded once on the input side, so both the output register
// and the skid register hold finished immediates together with their tag.
// A beat accepted in cycle N is presented with o_valid=1 in cycle N+1.
// Parameters:
//   XLEN   immediate width, 32 or 64
//   TAG_W  sideband tag width (>= 1)
// Ports:
//   i_clk       in  1      clock
//   i_rst       in  1      synchronous reset, active-high
//   i_valid     in  1      upstream beat valid
//   o_ready     out 1      block can accept a beat (low only when both entries full)
//   i_inst      in  32     instruction word
//   i_format    in  6      one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J
//   i_tag       in  TAG_W  sideband carried with the beat
//   o_valid     out 1      output beat valid
//   i_ready     in  1      downstream accepts the beat
//   o_immediate out XLEN   sign-extended immediate
//   o_tag       out TAG_W  tag of the output beat
//   o_fmt_err   out 1      only with IMM_FORMAT_CHECK_EN: format was not one-hot
// Build macro: IMM_FORMAT_CHECK_EN enables the o_fmt_err port and its logic.
// ----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_inst,
    input  logic [FMT_W-1:0]  i_format,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_immediate,
    output logic [TAG_W-1:0]  o_tag
`ifdef IMM_FORMAT_CHECK_EN
    ,
    output logic              o_fmt_err
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $fatal(1, "imm_gen_pipe: TAG_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Input-side decode
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_in_imm;

    imm_extract #(
        .XLEN (XLEN)
    ) u_imm_extract (
        .i_inst      (i_inst),
        .i_format    (i_format),
        .o_immediate (w_in_imm)
    );

`ifdef IMM_FORMAT_CHECK_EN
    logic w_in_err;
    // Zero bits set, or more than one bit set (x & (x-1) clears the lowest one).
    assign w_in_err = (i_format == '0) ||
                      ((i_format & (i_format - FMT_W'(1))) != '0);
`endif

    // ------------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------------
    state_e           r_state;
    state_e           w_state_nxt;

    logic [XLEN-1:0]  r_out_imm;
    logic [XLEN-1:0]  w_out_imm_nxt;
    logic [TAG_W-1:0] r_out_tag;
    logic [TAG_W-1:0] w_out_tag_nxt;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  w_skid_imm_nxt;
    logic [TAG_W-1:0] r_skid_tag;
    logic [TAG_W-1:0] w_skid_tag_nxt;
`ifdef IMM_FORMAT_CHECK_EN
    logic             r_out_err;
    logic             w_out_err_nxt;
    logic             r_skid_err;
    logic             w_skid_err_nxt;
`endif

    logic w_accept;
    logic w_emit;

    // Handshake outputs depend on state only, never on i_valid / i_ready.
    assign o_ready  = (r_state != FULL);
    assign o_valid  = (r_state != EMPTY);
    assign w_accept = i_valid && o_ready;
    assign w_emit   = o_valid && i_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_out_imm_nxt  = r_out_imm;
        w_out_tag_nxt  = r_out_tag;
        w_skid_imm_nxt = r_skid_imm;
        w_skid_tag_nxt = r_skid_tag;
`ifdef IMM_FORMAT_CHECK_EN
        w_out_err_nxt  = r_out_err;
        w_skid_err_nxt = r_skid_err;
`endif
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ONE;
                    w_out_imm_nxt = w_in_imm;
                    w_out_tag_nxt = i_tag;
`ifdef IMM_FORMAT_CHECK_EN
                    w_out_err_nxt = w_in_err;
`endif
                end
            end
            ONE: begin
                if (w_accept && !w_emit) begin
                    // Output is stalled: park the new beat behind it.
                    w_state_nxt    = FULL;
                    w_skid_imm_nxt = w_in_imm;
                    w_skid_tag_nxt = i_tag;
`ifdef IMM_FORMAT_CHECK_EN
                    w_skid_err_nxt = w_in_err;
`endif
                end else if (w_accept && w_emit) begin
                    w_out_imm_nxt = w_in_imm;
                    w_out_tag_nxt = i_tag;
`ifdef IMM_FORMAT_CHECK_EN
                    w_out_err_nxt = w_in_err;
`endif
                end else if (w_emit) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                // o_ready is low here, so only the emit side can move.
                if (w_emit) begin
                    w_state_nxt   = ONE;
                    w_out_imm_nxt = r_skid_imm;
                    w_out_tag_nxt = r_skid_tag;
`ifdef IMM_FORMAT_CHECK_EN
                    w_out_err_nxt = r_skid_err;
`endif
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= EMPTY;
            r_out_imm  <= '0;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
`ifdef IMM_FORMAT_CHECK_EN
            r_out_err  <= 1'b0;
            r_skid_err <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_out_imm  <= w_out_imm_nxt;
            r_out_tag  <= w_out_tag_nxt;
            r_skid_imm <= w_skid_imm_nxt;
            r_skid_tag <= w_skid_tag_nxt;
`ifdef IMM_FORMAT_CHECK_EN
            r_out_err  <= w_out_err_nxt;
            r_skid_err <= w_skid_err_nxt;
`endif
        end
    end

    assign o_immediate = r_out_imm;
    assign o_tag       = r_out_tag;
`ifdef IMM_FORMAT_CHECK_EN
    assign o_fmt_err   = r_out_err;
`endif

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. Two instances share all inputs: one with
// XLEN=32 and one with XLEN=64, so every vector carries both expected widths.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 32;

    localparam logic [5:0] F_R   = 6'b000001;
    localparam logic [5:0] F_I   = 6'b000010;
    localparam logic [5:0] F_S   = 6'b000100;
    localparam logic [5:0] F_B   = 6'b001000;
    localparam logic [5:0] F_U   = 6'b010000;
    localparam logic [5:0] F_J   = 6'b100000;
    localparam logic [5:0] F_IS  = 6'b000110;
    localparam logic [5:0] F_NON = 6'b000000;

    logic             clk;
    logic             i_rst;
    logic             i_valid;
    logic [31:0]      i_inst;
    logic [5:0]       i_format;
    logic [TAG_W-1:0] i_tag;
    logic             i_ready;

    logic             o_ready32;
    logic             o_valid32;
    logic [31:0]      o_imm32;
    logic [TAG_W-1:0] o_tag32;
    logic             o_ready64;
    logic             o_valid64;
    logic [63:0]      o_imm64;
    logic [TAG_W-1:0] o_tag64;
`ifdef IMM_FORMAT_CHECK_EN
    logic             o_err32;
    logic             o_err64;
`endif

    int n_vec;
    int n_miscompare;

    imm_gen_pipe #(
        .XLEN  (32),
        .TAG_W (TAG_W)
    ) u_dut32 (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready32),
        .i_inst      (i_inst),
        .i_format    (i_format),
        .i_tag       (i_tag),
        .o_valid     (o_valid32),
        .i_ready     (i_ready),
        .o_immediate (o_imm32),
        .o_tag       (o_tag32)
`ifdef IMM_FORMAT_CHECK_EN
        ,
        .o_fmt_err   (o_err32)
`endif
    );

    imm_gen_pipe #(
        .XLEN  (64),
        .TAG_W (TAG_W)
    ) u_dut64 (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready64),
        .i_inst      (i_inst),
        .i_format    (i_format),
        .i_tag       (i_tag),
        .o_valid     (o_valid64),
        .i_ready     (i_ready),
        .o_immediate (o_imm64),
        .o_tag       (o_tag64)
`ifdef IMM_FORMAT_CHECK_EN
        ,
        .o_fmt_err   (o_err64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat with i_ready=1 and check it on the next cycle.
    task automatic send(input string name, input logic [31:0] inst, input logic [5:0] fmt,
                        input logic [31:0] tag, input logic [31:0] exp32,
                        input logic [63:0] exp64, input logic exp_err);
        i_valid  = 1'b1;
        i_inst   = inst;
        i_format = fmt;
        i_tag    = tag;
        check_eq({name, "_ready"}, {63'h0, o_ready32}, 64'd1);
        tick();
        check_eq({name, "_valid32"}, {63'h0, o_valid32}, 64'd1);
        check_eq({name, "_valid64"}, {63'h0, o_valid64}, 64'd1);
        check_eq({name, "_imm32"}, {32'h0, o_imm32}, {32'h0, exp32});
        check_eq({name, "_imm64"}, o_imm64, exp64);
        check_eq({name, "_tag"}, {32'h0, o_tag32}, {32'h0, tag});
`ifdef IMM_FORMAT_CHECK_EN
        check_eq({name, "_err32"}, {63'h0, o_err32}, {63'h0, exp_err});
        check_eq({name, "_err64"}, {63'h0, o_err64}, {63'h0, exp_err});
`else
        if (exp_err === 1'bx) $display("note: unexpected X flag in vector %s", name);
`endif
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_inst       = 32'h0;
        i_format     = F_NON;
        i_tag        = '0;
        i_ready      = 1'b1;

        // Reset state.
        tick();
        check_eq("rst_ready_during", {63'h0, o_ready32}, 64'd1);
        tick();
        i_rst = 1'b0;
        check_eq("rst_valid", {63'h0, o_valid32}, 64'd0);
        check_eq("rst_imm32", {32'h0, o_imm32}, 64'd0);
        check_eq("rst_imm64", o_imm64, 64'd0);
        check_eq("rst_tag", {32'h0, o_tag32}, 64'd0);
        check_eq("rst_ready", {63'h0, o_ready64}, 64'd1);
`ifdef IMM_FORMAT_CHECK_EN
        check_eq("rst_err", {63'h0, o_err32}, 64'd0);
`endif

        // Decode vectors, streamed back to back with i_ready=1.
        send("i_neg", 32'hFFF00093, F_I, 32'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        send("i_pos", 32'h00500093, F_I, 32'd2, 32'h00000005, 64'h00000000_00000005, 1'b0);
        send("s_neg", 32'hFE112E23, F_S, 32'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        send("b_neg", 32'hFE000EE3, F_B, 32'd4, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        send("j_neg", 32'hFFDFF06F, F_J, 32'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        send("j_pos", 32'h0080006F, F_J, 32'd6, 32'h00000008, 64'h00000000_00000008, 1'b0);
        send("u_neg", 32'h800000B7, F_U, 32'd7, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
        send("u_pos", 32'h123450B7, F_U, 32'd8, 32'h12345000, 64'h00000000_12345000, 1'b0);
        send("r_any", 32'hFFFFFFFF, F_R, 32'd9, 32'h00000000, 64'h00000000_00000000, 1'b0);
        send("multi", 32'hFFF00093, F_IS, 32'd10, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
        send("none", 32'hFFF00093, F_NON, 32'd11, 32'h00000000, 64'h00000000_00000000, 1'b1);

        i_valid = 1'b0;
        tick();
        check_eq("drain_empty", {63'h0, o_valid32}, 64'd0);

        // Back-pressure: tags 1 and 2 fill the pipe, tag 3 waits upstream.
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_format = F_I;
        i_inst   = 32'h00100093;
        i_tag    = 32'd1;
        tick();
        check_eq("bp_one_tag", {32'h0, o_tag32}, 64'd1);
        check_eq("bp_one_ready", {63'h0, o_ready32}, 64'd1);
        i_inst = 32'h00200093;
        i_tag  = 32'd2;
        tick();
        check_eq("bp_full_ready", {63'h0, o_ready32}, 64'd0);
        check_eq("bp_full_tag", {32'h0, o_tag32}, 64'd1);
        i_inst = 32'h00300093;
        i_tag  = 32'd3;
        tick();
        check_eq("bp_hold_ready", {63'h0, o_ready32}, 64'd0);
        check_eq("bp_hold_tag", {32'h0, o_tag32}, 64'd1);
        check_eq("bp_hold_imm", {32'h0, o_imm32}, 64'd1);

        // Release: tags must appear 1,2,3 on consecutive cycles.
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic took;
            check_eq($sformatf("rel_valid%0d", k), {63'h0, o_valid32}, 64'd1);
            check_eq($sformatf("rel_tag%0d", k), {32'h0, o_tag32}, 64'(k + 1));
            check_eq($sformatf("rel_imm%0d", k), {32'h0, o_imm32}, 64'(k + 1));
            took = i_valid && o_ready32;
            tick();
            if (took) i_valid = 1'b0;
        end
        check_eq("rel_empty", {63'h0, o_valid32}, 64'd0);

        // Reset while FULL discards both entries and ignores the beat presented.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_tag   = 32'd4;
        tick();
        i_tag = 32'd5;
        tick();
        check_eq("rf_full", {63'h0, o_ready32}, 64'd0);
        i_rst = 1'b1;
        i_tag = 32'd6;
        tick();
        i_rst   = 1'b0;
        i_valid = 1'b0;
        check_eq("rf_valid", {63'h0, o_valid32}, 64'd0);
        check_eq("rf_ready", {63'h0, o_ready32}, 64'd1);
        check_eq("rf_tag", {32'h0, o_tag32}, 64'd0);
        check_eq("rf_imm64", o_imm64, 64'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("rf_stale%0d", k), {63'h0, o_valid32 | o_valid64}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule : tb_imm_gen_pipe
